// File: rtl/inc_dec_pkg.sv
// rtl/inc_dec_pkg.sv - shared FSM encoding and elaboration helpers for the inc/dec register bank
package inc_dec_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  function automatic int ch_lsb(input int ch, input int bits);
    return ch * bits;
  endfunction

endpackage

// File: rtl/inc_dec_step_calc.sv
// rtl/inc_dec_step_calc.sv - combinational one-step next value for a single channel
module inc_dec_step_calc #(
  parameter int BITS_NUM = 8,
  parameter int STEP     = 1,
  parameter int MIN_VAL  = 0,
  parameter int MAX_VAL  = 2**BITS_NUM-1,
  parameter int WRAP_EN  = 0
) (
  input  logic [BITS_NUM-1:0] q_i,
  input  logic                dir_i,
  input  logic                mode_i,
  output logic [BITS_NUM-1:0] q_o
);

  localparam int N = BITS_NUM + 1;
  localparam logic [N-1:0] STEP_W    = N'(STEP);
  localparam logic [N-1:0] MIN_W     = N'(MIN_VAL);
  localparam logic [N-1:0] MAX_W     = N'(MAX_VAL);
  localparam logic [N-1:0] DEC_THR_W = N'(MIN_VAL + STEP);
  localparam logic [N-1:0] RANGE_W   = N'(MAX_VAL - MIN_VAL + 1);
  localparam logic [N-1:0] DEC_BASE_W = N'(MAX_VAL - MIN_VAL - STEP + 1);

  logic [N-1:0] q_w;
  logic [N-1:0] sum_w;
  logic [N-1:0] res_w;
  logic         wrap;
  logic         unused_msb;

  // Wrapping needs both the build-time capability and the runtime mode select.
  assign wrap = mode_i && (WRAP_EN != 0);

  always_comb begin
    q_w   = {1'b0, q_i};
    sum_w = q_w + STEP_W;
    res_w = q_w;
    if (dir_i) begin
      if (sum_w > MAX_W) res_w = wrap ? (sum_w - RANGE_W) : MAX_W;
      else               res_w = sum_w;
    end else begin
      if (q_w < DEC_THR_W) res_w = wrap ? (DEC_BASE_W + q_w) : MIN_W;
      else                 res_w = q_w - STEP_W;
    end
  end

  assign q_o        = res_w[BITS_NUM-1:0];
  assign unused_msb = res_w[N-1];

endmodule

// File: rtl/inc_dec_reg_bank.sv
// rtl/inc_dec_reg_bank.sv - multi-channel up/down register bank with limits and hold-to-repeat
module inc_dec_reg_bank
  import inc_dec_pkg::*;
#(
  parameter int BITS_NUM      = 8,
  parameter int CH_NUM        = 4,
  parameter int STEP          = 1,
  parameter int MIN_VAL       = 0,
  parameter int MAX_VAL       = 2**BITS_NUM-1,
  parameter int RESET_VAL     = 0,
  parameter int WRAP_EN       = 0,
  parameter int HOLD_CYCLES   = 8,
  parameter int REPEAT_CYCLES = 2,
  localparam int CW = (CH_NUM > 1) ? clog2(CH_NUM) : 1
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic                       CLR,
  input  logic                       CE,
  input  logic [CW-1:0]              CH_SEL,
  input  logic                       INC_EN,
  input  logic                       DEC_EN,
  input  logic                       LOAD_EN,
  input  logic [BITS_NUM-1:0]        LOAD_VAL,
  output logic [CH_NUM*BITS_NUM-1:0] Q,
  output logic [CH_NUM-1:0]          AT_MIN,
  output logic [CH_NUM-1:0]          AT_MAX,
  output logic                       STEP_PULSE
);

  localparam int TMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int TW   = clog2(TMAX + 1);
  localparam logic [TW-1:0]       HOLD_T  = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0]       REP_T   = TW'(REPEAT_CYCLES - 1);
  localparam logic [TW-1:0]       ONE_T   = TW'(1);
  localparam logic [BITS_NUM-1:0] MIN_B   = BITS_NUM'(MIN_VAL);
  localparam logic [BITS_NUM-1:0] MAX_B   = BITS_NUM'(MAX_VAL);
  localparam logic [BITS_NUM-1:0] RESET_B = BITS_NUM'(RESET_VAL);

  state_e              state_q, state_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic                dir_q, dir_d;
  logic [CW-1:0]       ch_q, ch_d;
  logic [BITS_NUM-1:0] val_q [CH_NUM];
  logic                pulse_q;

  logic                sel_valid;
  logic                req;
  logic                press_new;
  logic                step_en;
  logic                load_en;
  logic [BITS_NUM-1:0] sel_val;
  logic [BITS_NUM-1:0] step_val;
  logic [BITS_NUM-1:0] load_clamped;

  // Out-of-range selects (non power-of-two CH_NUM) are ignored rather than aliased.
  assign sel_valid = int'(CH_SEL) < CH_NUM;
  assign sel_val   = sel_valid ? val_q[CH_SEL] : '0;
  assign req       = (INC_EN ^ DEC_EN) & sel_valid;
  assign press_new = req && ((state_q == ST_IDLE) || (INC_EN != dir_q) || (CH_SEL != ch_q));

  assign load_clamped = (int'(LOAD_VAL) < MIN_VAL) ? MIN_B :
                        (int'(LOAD_VAL) > MAX_VAL) ? MAX_B : LOAD_VAL;

  inc_dec_step_calc #(
    .BITS_NUM (BITS_NUM),
    .STEP     (STEP),
    .MIN_VAL  (MIN_VAL),
    .MAX_VAL  (MAX_VAL),
    .WRAP_EN  (WRAP_EN)
  ) u_step_calc (
    .q_i    (sel_val),
    .dir_i  (INC_EN),
    .mode_i (WRAP_EN != 0),
    .q_o    (step_val)
  );

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    dir_d   = dir_q;
    ch_d    = ch_q;
    step_en = 1'b0;
    load_en = 1'b0;
    if (CLR) begin
      state_d = ST_IDLE;
      timer_d = '0;
    end else if (CE) begin
      if (LOAD_EN) begin
        load_en = sel_valid;
        state_d = ST_IDLE;
        timer_d = '0;
      end else if (!req) begin
        state_d = ST_IDLE;
      end else if (press_new) begin
        step_en = 1'b1;
        dir_d   = INC_EN;
        ch_d    = CH_SEL;
        timer_d = HOLD_T;
        state_d = ST_DELAY;
      end else if (timer_q == '0) begin
        step_en = 1'b1;
        timer_d = REP_T;
        state_d = ST_REPEAT;
      end else begin
        timer_d = timer_q - ONE_T;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      dir_q   <= 1'b0;
      ch_q    <= '0;
      pulse_q <= 1'b0;
      for (int i = 0; i < CH_NUM; i++) val_q[i] <= RESET_B;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      dir_q   <= dir_d;
      ch_q    <= ch_d;
      pulse_q <= step_en;
      if (CLR) begin
        for (int i = 0; i < CH_NUM; i++) val_q[i] <= RESET_B;
      end else if (load_en) begin
        val_q[CH_SEL] <= load_clamped;
      end else if (step_en) begin
        val_q[CH_SEL] <= step_val;
      end
    end
  end

  for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
    assign Q[ch_lsb(i, BITS_NUM) +: BITS_NUM] = val_q[i];
    assign AT_MIN[i] = (val_q[i] == MIN_B);
    assign AT_MAX[i] = (val_q[i] == MAX_B);
  end

  assign STEP_PULSE = pulse_q;

endmodule

// File: tb/tb_inc_dec_reg_bank.sv
// tb/tb_inc_dec_reg_bank.sv - self-checking bench for inc_dec_reg_bank over three configurations
module tb_inc_dec_reg_bank;

  localparam int H = 4;
  localparam int R = 2;

  logic       clk = 1'b0;
  logic       rst_n, clr, ce, inc_en, dec_en, load_en;
  logic [1:0] ch_sel;
  logic [7:0] load_val;

  logic [31:0] q_a;
  logic [3:0]  amin_a, amax_a;
  logic        sp_a;
  logic [5:0]  q_b, q_c;
  logic [1:0]  amin_b, amax_b, amin_c, amax_c;
  logic        sp_b, sp_c;

  int checks = 0;
  int errors = 0;
  int pulses;

  // Instance 0: 8-bit, 4 channels, saturate, limit 100, reset 5. Instances 1/2: 3-bit, step 3, sat/wrap.
  int c_bits [3] = '{8, 3, 3};
  int c_chn  [3] = '{4, 2, 2};
  int c_step [3] = '{1, 3, 3};
  int c_min  [3] = '{0, 0, 0};
  int c_max  [3] = '{100, 7, 7};
  int c_rst  [3] = '{5, 0, 0};
  int c_wrap [3] = '{0, 0, 1};

  int m_q     [3][4];
  int m_age   [3];
  bit m_dir   [3];
  int m_ch    [3];
  bit m_pulse [3];

  always #5 clk = ~clk;

  inc_dec_reg_bank #(
    .BITS_NUM(8), .CH_NUM(4), .STEP(1), .MIN_VAL(0), .MAX_VAL(100), .RESET_VAL(5),
    .WRAP_EN(0), .HOLD_CYCLES(H), .REPEAT_CYCLES(R)
  ) dut_a (
    .CLK(clk), .RST_N(rst_n), .CLR(clr), .CE(ce), .CH_SEL(ch_sel),
    .INC_EN(inc_en), .DEC_EN(dec_en), .LOAD_EN(load_en), .LOAD_VAL(load_val),
    .Q(q_a), .AT_MIN(amin_a), .AT_MAX(amax_a), .STEP_PULSE(sp_a)
  );

  inc_dec_reg_bank #(
    .BITS_NUM(3), .CH_NUM(2), .STEP(3), .MIN_VAL(0), .MAX_VAL(7), .RESET_VAL(0),
    .WRAP_EN(0), .HOLD_CYCLES(H), .REPEAT_CYCLES(R)
  ) dut_b (
    .CLK(clk), .RST_N(rst_n), .CLR(clr), .CE(ce), .CH_SEL(ch_sel[0:0]),
    .INC_EN(inc_en), .DEC_EN(dec_en), .LOAD_EN(load_en), .LOAD_VAL(load_val[2:0]),
    .Q(q_b), .AT_MIN(amin_b), .AT_MAX(amax_b), .STEP_PULSE(sp_b)
  );

  inc_dec_reg_bank #(
    .BITS_NUM(3), .CH_NUM(2), .STEP(3), .MIN_VAL(0), .MAX_VAL(7), .RESET_VAL(0),
    .WRAP_EN(1), .HOLD_CYCLES(H), .REPEAT_CYCLES(R)
  ) dut_c (
    .CLK(clk), .RST_N(rst_n), .CLR(clr), .CE(ce), .CH_SEL(ch_sel[0:0]),
    .INC_EN(inc_en), .DEC_EN(dec_en), .LOAD_EN(load_en), .LOAD_VAL(load_val[2:0]),
    .Q(q_c), .AT_MIN(amin_c), .AT_MAX(amax_c), .STEP_PULSE(sp_c)
  );

  function automatic int next_val(input int k, input int v, input bit up);
    int t;
    int span;
    t    = up ? v + c_step[k] : v - c_step[k];
    span = c_max[k] - c_min[k] + 1;
    if (c_wrap[k] != 0) return c_min[k] + (((t - c_min[k]) % span) + span) % span;
    if (t > c_max[k]) return c_max[k];
    if (t < c_min[k]) return c_min[k];
    return t;
  endfunction

  function automatic int clamp_val(input int k, input int v);
    if (v < c_min[k]) return c_min[k];
    if (v > c_max[k]) return c_max[k];
    return v;
  endfunction

  task automatic model_reset(input int k);
    for (int c = 0; c < 4; c++) m_q[k][c] = c_rst[k];
    m_age[k]   = -1;
    m_pulse[k] = 1'b0;
  endtask

  // The model tracks how long the current press has been held, in CE cycles.
  task automatic model_cycle(input int k);
    int ch;
    int lv;
    ch = int'(ch_sel) % c_chn[k];
    lv = int'(load_val) % (1 << c_bits[k]);
    m_pulse[k] = 1'b0;
    if (clr) begin
      model_reset(k);
    end else if (ce) begin
      if (load_en) begin
        m_q[k][ch] = clamp_val(k, lv);
        m_age[k]   = -1;
      end else if (inc_en ^ dec_en) begin
        if (m_age[k] < 0 || m_dir[k] != inc_en || m_ch[k] != ch) begin
          m_age[k] = 0;
          m_dir[k] = inc_en;
          m_ch[k]  = ch;
        end else begin
          m_age[k]++;
        end
        if (m_age[k] == 0 || (m_age[k] >= H && (m_age[k] - H) % R == 0)) begin
          m_q[k][ch] = next_val(k, m_q[k][ch], inc_en);
          m_pulse[k] = 1'b1;
        end
      end else begin
        m_age[k] = -1;
      end
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 3; k++) begin
      if (!rst_n) model_reset(k);
      else        model_cycle(k);
    end
  end

  function automatic int dut_q(input int k, input int c);
    case (k)
      0:       return int'(q_a[c*8 +: 8]);
      1:       return int'(q_b[c*3 +: 3]);
      default: return int'(q_c[c*3 +: 3]);
    endcase
  endfunction

  function automatic int dut_min(input int k, input int c);
    case (k)
      0:       return int'(amin_a[c]);
      1:       return int'(amin_b[c]);
      default: return int'(amin_c[c]);
    endcase
  endfunction

  function automatic int dut_max(input int k, input int c);
    case (k)
      0:       return int'(amax_a[c]);
      1:       return int'(amax_b[c]);
      default: return int'(amax_c[c]);
    endcase
  endfunction

  function automatic int dut_pulse(input int k);
    case (k)
      0:       return int'(sp_a);
      1:       return int'(sp_b);
      default: return int'(sp_c);
    endcase
  endfunction

  task automatic cmp(input string name, input int k, input int c, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s inst%0d ch%0d at %0t: got %0d expected %0d", name, k, c, $time, got, exp);
    end
  endtask

  task automatic lit(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 3; k++) begin
        for (int c = 0; c < c_chn[k]; c++) begin
          cmp("q", k, c, dut_q(k, c), m_q[k][c]);
          cmp("at_min", k, c, dut_min(k, c), int'(m_q[k][c] == c_min[k]));
          cmp("at_max", k, c, dut_max(k, c), int'(m_q[k][c] == c_max[k]));
        end
        cmp("step_pulse", k, 0, dut_pulse(k), int'(m_pulse[k]));
      end
    end
  end

  initial begin
    rst_n = 1'b0; clr = 1'b0; ce = 1'b1; inc_en = 1'b0; dec_en = 1'b0;
    load_en = 1'b0; ch_sel = 2'd0; load_val = 8'd0;
    repeat (2) @(negedge clk);
    lit("rst_a_ch0", int'(q_a[7:0]), 5);
    lit("rst_a_ch3", int'(q_a[31:24]), 5);
    lit("rst_b", int'(q_b), 0);
    lit("rst_pulse", int'(sp_a), 0);
    rst_n = 1'b1;
    @(negedge clk);

    ch_sel = 2'd2; inc_en = 1'b1;
    @(negedge clk);
    lit("press_a_ch2", int'(q_a[23:16]), 6);
    lit("press_a_ch1", int'(q_a[15:8]), 5);
    lit("press_pulse", int'(sp_a), 1);
    lit("press_b_ch0", int'(q_b[2:0]), 3);
    inc_en = 1'b0;
    @(negedge clk);
    lit("press_pulse_end", int'(sp_a), 0);

    ch_sel = 2'd1; inc_en = 1'b1; pulses = 0;
    repeat (10) begin
      @(negedge clk);
      pulses += int'(sp_a);
    end
    inc_en = 1'b0;
    @(negedge clk);
    lit("hold_a_ch1", int'(q_a[15:8]), 9);
    lit("hold_pulses", pulses, 4);
    lit("hold_b_ch1_sat", int'(q_b[5:3]), 7);
    lit("hold_b_atmax", int'(amax_b[1]), 1);
    lit("hold_c_ch1_wrap", int'(q_c[5:3]), 4);

    ch_sel = 2'd0; load_en = 1'b1; load_val = 8'd6;
    @(negedge clk);
    load_en = 1'b0;
    lit("load_c_ch0", int'(q_c[2:0]), 6);
    inc_en = 1'b1;
    @(negedge clk);
    inc_en = 1'b0;
    lit("sat_inc_b", int'(q_b[2:0]), 7);
    lit("sat_inc_b_atmax", int'(amax_b[0]), 1);
    lit("wrap_inc_c", int'(q_c[2:0]), 1);
    lit("inc_a_ch0", int'(q_a[7:0]), 7);
    @(negedge clk);
    dec_en = 1'b1;
    @(negedge clk);
    dec_en = 1'b0;
    lit("wrap_dec_c", int'(q_c[2:0]), 6);
    lit("sat_dec_b", int'(q_b[2:0]), 4);

    inc_en = 1'b1; dec_en = 1'b1;
    @(negedge clk);
    lit("both_pulse", int'(sp_a), 0);
    lit("both_a_ch0", int'(q_a[7:0]), 6);
    dec_en = 1'b0; ce = 1'b0;
    @(negedge clk);
    lit("freeze_a_ch0", int'(q_a[7:0]), 6);
    lit("freeze_pulse", int'(sp_a), 0);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0; inc_en = 1'b0; ce = 1'b1;
    lit("clr_a_ch1", int'(q_a[15:8]), 5);
    lit("clr_b", int'(q_b), 0);
    lit("clr_c", int'(q_c), 0);

    ch_sel = 2'd2; inc_en = 1'b1;
    @(negedge clk);
    load_en = 1'b1; load_val = 8'd200;
    @(negedge clk);
    load_en = 1'b0;
    lit("load_clamp_a", int'(q_a[23:16]), 100);
    lit("load_pulse", int'(sp_a), 0);
    lit("load_atmax", int'(amax_a[2]), 1);
    @(negedge clk);
    lit("post_load_press_pulse", int'(sp_a), 1);
    lit("post_load_sat", int'(q_a[23:16]), 100);
    inc_en = 1'b0;
    @(negedge clk);

    ch_sel = 2'd1; inc_en = 1'b1;
    @(negedge clk);
    lit("sw_a_ch1", int'(q_a[15:8]), 6);
    ch_sel = 2'd3;
    @(negedge clk);
    lit("sw_a_ch3", int'(q_a[31:24]), 6);
    lit("sw_pulse", int'(sp_a), 1);
    lit("sw_a_ch1_kept", int'(q_a[15:8]), 6);
    repeat (3) @(negedge clk);
    lit("sw_a_ch3_delay", int'(q_a[31:24]), 6);
    @(negedge clk);
    lit("sw_a_ch3_restep", int'(q_a[31:24]), 7);
    inc_en = 1'b0;
    @(negedge clk);

    ch_sel = 2'd0; inc_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      ce = (i % 2 == 0);
      @(negedge clk);
    end
    inc_en = 1'b0; ce = 1'b1;
    @(negedge clk);
    lit("gated_a_ch0", int'(q_a[7:0]), 8);

    ch_sel = 2'd2; load_en = 1'b1; load_val = 8'd40;
    @(negedge clk);
    load_en = 1'b0; inc_en = 1'b1;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    lit("rst_mid_a_ch2", int'(q_a[23:16]), 5);
    lit("rst_mid_a_ch0", int'(q_a[7:0]), 5);
    lit("rst_mid_pulse", int'(sp_a), 0);
    lit("rst_mid_c", int'(q_c), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    lit("rst_release_step", int'(q_a[23:16]), 6);
    lit("rst_release_pulse", int'(sp_a), 1);
    inc_en = 1'b0;
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
